// File: rtl/prog_loader.sv
// UART (8N1) program loader: 4-byte frames {addr_hi, addr_lo, data_hi, data_lo} become one instruction-memory write.
// Define PROG_LOADER_CHECKSUM_EN to add a 5th byte holding the XOR of the other four. prog_ld follows the last stop-bit sample by one cycle.
// There is no backpressure: the serial line cannot be stalled, and a partial frame is dropped after TIMEOUT_BITS idle bit periods.
module prog_loader #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic        clk,
    input  logic        pc_reset_n,
    input  logic        uart_rx,
    output logic [15:0] bluetooth_addr,
    output logic [15:0] bluetooth_data,
    output logic        prog_ld,
    output logic        frame_err,
    output logic [15:0] word_count
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] HALF   = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] FULL   = 16'(CLKS_PER_BIT);
    localparam logic [31:0] TO_MAX = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam logic [2:0]  LAST   = 3'd4;
`else
    localparam logic [2:0]  LAST   = 3'd3;
`endif

    state_t      r_state;
    logic        r_sync1, r_sync2, r_rx_prev;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic [2:0]  r_idx;
    logic [31:0] r_idle_cnt;
    logic [7:0]  r_b0, r_b1, r_b2;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]  r_b3;
`endif
    logic        w_fall;
    logic        w_tick;

    assign w_fall = r_rx_prev & ~r_sync2;
    assign w_tick = (r_cnt == 16'd1);

    always_ff @(posedge clk or negedge pc_reset_n) begin
        if (!pc_reset_n) begin
            r_state        <= IDLE;
            r_sync1        <= 1'b1;
            r_sync2        <= 1'b1;
            r_rx_prev      <= 1'b1;
            r_cnt          <= '0;
            r_bit          <= '0;
            r_shift        <= '0;
            r_idx          <= '0;
            r_idle_cnt     <= '0;
            r_b0           <= '0;
            r_b1           <= '0;
            r_b2           <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_b3           <= '0;
`endif
            bluetooth_addr <= '0;
            bluetooth_data <= '0;
            prog_ld        <= 1'b0;
            frame_err      <= 1'b0;
            word_count     <= '0;
        end else begin
            r_sync1   <= uart_rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
            prog_ld   <= 1'b0;
            frame_err <= 1'b0;

            // Inter-byte silence inside a frame resynchronises the byte index.
            if (r_state == IDLE && r_idx != 3'd0) begin
                if (r_idle_cnt == TO_MAX) begin
                    r_idx      <= '0;
                    r_idle_cnt <= '0;
                end else begin
                    r_idle_cnt <= r_idle_cnt + 32'd1;
                end
            end else begin
                r_idle_cnt <= '0;
            end

            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state <= START;
                        r_cnt   <= HALF;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_cnt <= FULL;
                        r_bit <= '0;
                        r_state <= r_sync2 ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift <= {r_sync2, r_shift[7:1]};
                        r_cnt   <= FULL;
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7)
                            r_state <= STOP;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_state <= IDLE;
                        if (!r_sync2) begin
                            frame_err <= 1'b1;
                            r_idx     <= '0;
                        end else begin
                            r_idx <= (r_idx == LAST) ? 3'd0 : r_idx + 3'd1;
                            case (r_idx)
                                3'd0: r_b0 <= r_shift;
                                3'd1: r_b1 <= r_shift;
                                3'd2: r_b2 <= r_shift;
`ifdef PROG_LOADER_CHECKSUM_EN
                                3'd3: r_b3 <= r_shift;
                                default: begin
                                    if ((r_b0 ^ r_b1 ^ r_b2 ^ r_b3) == r_shift) begin
                                        bluetooth_addr <= {r_b0, r_b1};
                                        bluetooth_data <= {r_b2, r_b3};
                                        prog_ld        <= 1'b1;
                                        word_count     <= word_count + 16'd1;
                                    end else begin
                                        frame_err <= 1'b1;
                                    end
                                end
`else
                                default: begin
                                    bluetooth_addr <= {r_b0, r_b1};
                                    bluetooth_data <= {r_b2, r_shift};
                                    prog_ld        <= 1'b1;
                                    word_count     <= word_count + 16'd1;
                                end
`endif
                            endcase
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: drives serial bytes and compares commits with a frame-level reference model.
module tb_prog_loader;
    localparam int CPB = 4;
    localparam int TOB = 4;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam int FLEN = 5;
`else
    localparam int FLEN = 4;
`endif

    logic        clk = 1'b0;
    logic        pc_reset_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic [15:0] bluetooth_addr, bluetooth_data, word_count;
    logic        prog_ld, frame_err;

    prog_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
        .clk(clk), .pc_reset_n(pc_reset_n), .uart_rx(uart_rx),
        .bluetooth_addr(bluetooth_addr), .bluetooth_data(bluetooth_data),
        .prog_ld(prog_ld), .frame_err(frame_err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] got_addr[$], got_data[$], got_wc[$];
    int          got_ferr = 0;
    logic [15:0] exp_addr[$], exp_data[$], exp_wc[$];
    int          exp_ferr = 0;
    logic [7:0]  m_buf[$];
    logic [15:0] m_count = 0, m_last_addr = 0, m_last_data = 0;

    always @(negedge clk) begin
        if (prog_ld) begin
            got_addr.push_back(bluetooth_addr);
            got_data.push_back(bluetooth_data);
            got_wc.push_back(word_count);
        end
        if (frame_err) got_ferr++;
    end

    // Reference model: bytes accumulate into a frame; a full frame commits (checksum permitting).
    task automatic model_byte(input logic [7:0] b, input bit good);
        bit ok;
        if (!good) begin
            m_buf.delete();
            exp_ferr++;
        end else begin
            m_buf.push_back(b);
            if (m_buf.size() == FLEN) begin
                ok = 1'b1;
                if (FLEN == 5) ok = ((m_buf[0] ^ m_buf[1] ^ m_buf[2] ^ m_buf[3]) == m_buf[FLEN-1]);
                if (ok) begin
                    m_count++;
                    m_last_addr = {m_buf[0], m_buf[1]};
                    m_last_data = {m_buf[2], m_buf[3]};
                    exp_addr.push_back(m_last_addr);
                    exp_data.push_back(m_last_data);
                    exp_wc.push_back(m_count);
                end else begin
                    exp_ferr++;
                end
                m_buf.delete();
            end
        end
    endtask

    task automatic new_test();
        got_addr.delete(); got_data.delete(); got_wc.delete();
        exp_addr.delete(); exp_data.delete(); exp_wc.delete();
        got_ferr = 0; exp_ferr = 0;
        @(posedge clk); #1;
    endtask

    task automatic send_bit(input logic v);
        uart_rx = v;
        repeat (CPB) begin @(posedge clk); #1; end
    endtask

    task automatic send_idle(input int nbits);
        uart_rx = 1'b1;
        repeat (nbits * CPB) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(good);
        uart_rx = 1'b1;
        model_byte(b, good);
    endtask

    task automatic send_frame(input logic [15:0] a, input logic [15:0] d, input int maxgap);
        logic [7:0] b[5];
        b[0] = a[15:8]; b[1] = a[7:0]; b[2] = d[15:8]; b[3] = d[7:0];
        b[4] = b[0] ^ b[1] ^ b[2] ^ b[3];
        for (int i = 0; i < FLEN; i++) begin
            send_byte(b[i], 1'b1);
            send_idle(int'($urandom_range(0, maxgap)));
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bluetooth_addr, bluetooth_data, word_count, prog_ld, frame_err} !== 50'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got addr=%h data=%h wc=%h ld=%b err=%b want all 0",
                     bluetooth_addr, bluetooth_data, word_count, prog_ld, frame_err);
        end
        pc_reset_n = 1'b1;
        send_idle(2);
    endtask

    task automatic test_single();
        new_test();
        send_frame(16'h0005, 16'hA123, 0);
        send_idle(3);
        n_checks++;
        if (got_addr.size() != 1) begin
            n_fail++; $display("FAIL single_count got %0d want 1", got_addr.size());
        end
        n_checks++;
        if (bluetooth_addr !== 16'h0005 || bluetooth_data !== 16'hA123 || word_count !== 16'd1) begin
            n_fail++;
            $display("FAIL single_values got %h/%h wc=%0d want 0005/a123 wc=1", bluetooth_addr, bluetooth_data, word_count);
        end
        n_checks++;
        if (got_wc.size() == 1 && got_wc[0] !== 16'd1) begin
            n_fail++; $display("FAIL single_wc_at_strobe got %0d want 1", got_wc[0]);
        end
    endtask

    task automatic test_back_to_back();
        new_test();
        send_frame(16'h0000, 16'h1111, 0);
        send_frame(16'h0001, 16'h2222, 0);
        send_idle(3);
        n_checks++;
        if (got_addr.size() != 2) begin
            n_fail++; $display("FAIL b2b_count got %0d want 2", got_addr.size());
        end else begin
            n_checks++;
            if (got_addr[0] !== 16'h0000 || got_data[0] !== 16'h1111 ||
                got_addr[1] !== 16'h0001 || got_data[1] !== 16'h2222) begin
                n_fail++;
                $display("FAIL b2b_order got %h/%h %h/%h want 0000/1111 0001/2222",
                         got_addr[0], got_data[0], got_addr[1], got_data[1]);
            end
        end
        n_checks++;
        if (word_count !== m_count) begin
            n_fail++; $display("FAIL b2b_wc got %0d want %0d", word_count, m_count);
        end
    endtask

    task automatic test_frame_err();
        new_test();
        send_byte(8'h12, 1'b0);
        send_idle(1);
        n_checks++;
        if (got_ferr != 1 || got_addr.size() != 0) begin
            n_fail++; $display("FAIL ferr_pulse got err=%0d ld=%0d want err=1 ld=0", got_ferr, got_addr.size());
        end
        send_frame(16'h0007, 16'hBEEF, 1);
        send_idle(3);
        n_checks++;
        if (got_addr.size() != 1 || bluetooth_addr !== 16'h0007 || bluetooth_data !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL ferr_recover got n=%0d %h/%h want n=1 0007/beef", got_addr.size(), bluetooth_addr, bluetooth_data);
        end
    endtask

    task automatic test_timeout();
        new_test();
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_idle(20);
        m_buf.delete();
        send_frame(16'h0009, 16'h0001, 1);
        send_idle(3);
        n_checks++;
        if (got_addr.size() != 1 || bluetooth_addr !== 16'h0009 || bluetooth_data !== 16'h0001 || got_ferr != 0) begin
            n_fail++;
            $display("FAIL timeout_commit got n=%0d %h/%h err=%0d want n=1 0009/0001 err=0",
                     got_addr.size(), bluetooth_addr, bluetooth_data, got_ferr);
        end
    endtask

    task automatic test_glitch();
        new_test();
        uart_rx = 1'b0;
        @(posedge clk); #1;
        send_idle(10);
        n_checks++;
        if (got_addr.size() != 0 || got_ferr != 0) begin
            n_fail++; $display("FAIL glitch_events got ld=%0d err=%0d want 0 0", got_addr.size(), got_ferr);
        end
        n_checks++;
        if (bluetooth_addr !== m_last_addr || bluetooth_data !== m_last_data || word_count !== m_count) begin
            n_fail++;
            $display("FAIL glitch_hold got %h/%h wc=%0d want %h/%h wc=%0d",
                     bluetooth_addr, bluetooth_data, word_count, m_last_addr, m_last_data, m_count);
        end
    endtask

    task automatic test_reset_mid();
        new_test();
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        pc_reset_n = 1'b0;
        uart_rx = 1'b1;
        #1;
        n_checks++;
        if ({bluetooth_addr, bluetooth_data, word_count, prog_ld, frame_err} !== 50'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs got addr=%h data=%h wc=%h want 0", bluetooth_addr, bluetooth_data, word_count);
        end
        m_buf.delete(); m_count = 0; m_last_addr = 0; m_last_data = 0;
        repeat (3) @(posedge clk);
        #1;
        pc_reset_n = 1'b1;
        send_idle(2);
        send_frame(16'h00AB, 16'hCDEF, 1);
        send_idle(3);
        n_checks++;
        if (got_addr.size() != 1 || bluetooth_addr !== 16'h00AB || bluetooth_data !== 16'hCDEF || word_count !== 16'd1) begin
            n_fail++;
            $display("FAIL reset_mid_fresh got n=%0d %h/%h wc=%0d want n=1 00ab/cdef wc=1",
                     got_addr.size(), bluetooth_addr, bluetooth_data, word_count);
        end
    endtask

`ifdef PROG_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] fr[5];
        new_test();
        fr[0] = 8'h00; fr[1] = 8'h01; fr[2] = 8'h12; fr[3] = 8'h34; fr[4] = 8'h27;
        for (int i = 0; i < 5; i++) send_byte(fr[i], 1'b1);
        send_idle(3);
        n_checks++;
        if (got_addr.size() != 1 || bluetooth_addr !== 16'h0001 || bluetooth_data !== 16'h1234 || got_ferr != 0) begin
            n_fail++;
            $display("FAIL cksum_good got n=%0d %h/%h err=%0d want n=1 0001/1234 err=0",
                     got_addr.size(), bluetooth_addr, bluetooth_data, got_ferr);
        end
        fr[4] = 8'h00;
        for (int i = 0; i < 5; i++) send_byte(fr[i], 1'b1);
        send_idle(3);
        n_checks++;
        if (got_addr.size() != 1 || got_ferr != 1) begin
            n_fail++; $display("FAIL cksum_bad got n=%0d err=%0d want n=1 err=1", got_addr.size(), got_ferr);
        end
    endtask
`endif

    task automatic test_random();
        int r, k;
        new_test();
        for (int it = 0; it < 16; it++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                k = int'($urandom_range(0, FLEN - 1));
                for (int j = 0; j < k; j++) send_byte(8'($urandom), 1'b1);
                send_byte(8'($urandom), 1'b0);
                send_idle(1);
            end else if (r == 1) begin
                k = int'($urandom_range(1, FLEN - 1));
                for (int j = 0; j < k; j++) send_byte(8'($urandom), 1'b1);
                send_idle(20);
                m_buf.delete();
            end else begin
                send_frame(16'($urandom), 16'($urandom), 1);
            end
        end
        send_idle(3);
        n_checks++;
        if (got_addr.size() != exp_addr.size()) begin
            n_fail++; $display("FAIL rand_count got %0d want %0d", got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            n_checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i] || got_wc[i] !== exp_wc[i]) begin
                n_fail++;
                $display("FAIL rand_commit[%0d] got %h/%h wc=%0d want %h/%h wc=%0d",
                         i, got_addr[i], got_data[i], got_wc[i], exp_addr[i], exp_data[i], exp_wc[i]);
            end
        end
        n_checks++;
        if (got_ferr != exp_ferr) begin
            n_fail++; $display("FAIL rand_ferr got %0d want %0d", got_ferr, exp_ferr);
        end
        n_checks++;
        if (word_count !== m_count) begin
            n_fail++; $display("FAIL rand_wc got %0d want %0d", word_count, m_count);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_timeout();
        test_glitch();
        test_reset_mid();
`ifdef PROG_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208: clk cycles per UART bit (9600 baud at 50 MHz); legal range 4..65535.
REQ-002 SHALL have parameter TIMEOUT_BITS, default 32: idle bit periods after which a partial frame is discarded.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port pc_reset_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port uart_rx, input, 1: serial line from the Bluetooth module, idle high, 8N1, LSB first.
REQ-006 SHALL have port bluetooth_addr, output, 16: instruction-memory write address.
REQ-007 SHALL have port bluetooth_data, output, 16: instruction word.
REQ-008 SHALL have port prog_ld, output, 1: one-cycle write strobe to instruction memory.
REQ-009 SHALL have port frame_err, output, 1: one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port word_count, output, 16: number of prog_ld strobes since reset, wraps 0xFFFF->0x0000.

Function
REQ-011 uart_rx SHALL pass through a 2-flop synchronizer before any use.
REQ-012 Receiver FSM states SHALL be IDLE, START, DATA, STOP.
REQ-013 IDLE->START on synchronized falling edge of uart_rx; bit counter loads CLKS_PER_BIT/2.
REQ-014 START: at counter expiry, line low -> DATA, line high -> IDLE (glitch rejected, no error).
REQ-015 DATA: 8 samples, each CLKS_PER_BIT cycles apart at bit centre, shifted LSB first; then -> STOP.
REQ-016 STOP: sample at centre; high -> byte valid for exactly one cycle, low -> frame_err pulse, byte dropped, frame byte index cleared; both -> IDLE.
REQ-017 Frame SHALL be 4 bytes in order: addr[15:8], addr[7:0], data[15:8], data[7:0].
REQ-018 Byte index 0..3 SHALL advance on each valid byte and wrap to 0 after the last byte.
REQ-019 On the final valid byte, bluetooth_addr/bluetooth_data SHALL update and prog_ld SHALL assert on the next rising edge, high for exactly one cycle.
REQ-020 bluetooth_addr/bluetooth_data SHALL hold their last committed values between strobes; partial frames SHALL never change them.
REQ-021 Idle counter SHALL run while byte index != 0 and FSM is IDLE; reaching TIMEOUT_BITS*CLKS_PER_BIT cycles SHALL clear byte index, no error pulse.
REQ-022 word_count SHALL increment in the same cycle prog_ld is high.
REQ-023 Receiving continues back-to-back; a start edge arriving in the cycle after a stop sample SHALL be accepted.

Reset
REQ-024 pc_reset_n low SHALL immediately force FSM to IDLE, byte index 0, synchronizer flops to 1, and all outputs to 0.
REQ-025 Reset mid-byte or mid-frame SHALL discard all partial data; reception resumes at the next falling edge after release.

Configuration
REQ-026 Macro PROG_LOADER_CHECKSUM_EN SHALL, when defined, append a 5th byte equal to XOR of the 4 preceding bytes; prog_ld fires only on match; mismatch pulses frame_err for one cycle and commits nothing.
REQ-027 Without PROG_LOADER_CHECKSUM_EN the frame SHALL be exactly 4 bytes and no checksum logic SHALL exist.

Verification (CLKS_PER_BIT=4, TIMEOUT_BITS=4)
REQ-028 Send bytes 00 05 A1 23 -> one prog_ld pulse with addr=0x0005, data=0xA123, word_count=1.
REQ-029 Two frames back-to-back (0x0000/0x1111, 0x0001/0x2222) -> two pulses, values in order, word_count=2.
REQ-030 Byte 0x12 with stop bit low -> frame_err pulse, no prog_ld; following full frame 00 07 BE EF commits addr=0x0007, data=0xBEEF.
REQ-031 2-byte partial frame, idle 20 bit times, then 00 09 00 01 -> single commit addr=0x0009, data=0x0001.
REQ-032 1-cycle low glitch on uart_rx while idle -> no byte, no error, outputs unchanged.
REQ-033 pc_reset_n pulsed low during 3rd byte -> outputs 0; a fresh frame after release commits correctly; with PROG_LOADER_CHECKSUM_EN, frame 00 01 12 34 + checksum 0x27 commits, checksum 0x00 -> frame_err only.
